memmu_sr_payload_writer: RTL and testbench
==========================================

// Module: memmu_sr_payload_writer
// PURPOSE
//  Write scheduler for the MemMU spherical-representation point store. Accepts SIU points
//  (valid/ready), packs each into the 64-bit SR payload, buffers up to FIFO_DEPTH entries, and
//  issues one memory write per point with a req/ack handshake. Sits between SIU and memory port.
//  Also keeps a per-frame count of committed writes.
// PARAMETERS
//  ADDR_W      32  memory byte-address width
//  IDX_W       16  width of point cell index from MemMU SR addressing
//  FIFO_DEPTH  4   payload/address buffer entries; power of two, >=2
// PORTS
//  i_SYSTEM_clk               in   1          clock; all logic on rising edge
//  i_SYSTEM_rst               in   1          synchronous, active-high reset
//  i_cfg_enable               in   1          1 = accept new points
//  i_cfg_clear                in   1          1-cycle pulse: zero write counter
//  i_cfg_base_addr            in   ADDR_W     base byte address of SR buffer
//  i_SIU_valid                in   1          point valid
//  o_SIU_ready                out  1          point accepted when valid & ready
//  i_SIU_distR0 / i_SIU_distR1  in 16 each    return distances
//  i_SIU_reflR0 / i_SIU_reflR1  in 8 each     return reflectivities
//  i_SIU_label                in   8          point label
//  i_MemMU_SR_A_correction    in   8          representation correction
//  i_MemMU_SR_A_index         in   IDX_W      cell index of point
//  o_MEM_wr_req               out  1          write request
//  o_MEM_wr_addr              out  ADDR_W     write byte address
//  o_MEM_wr_data              out  64         packed payload
//  i_MEM_wr_ack               in   1          write accepted (counted only while req=1)
//  o_MemMU_SR_W_count         out  IDX_W+1    committed writes since reset/clear
//  o_MemMU_SR_W_busy          out  1          FIFO non-empty or req asserted
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO flushed; FSM=IDLE. Reset mid-transfer drops req at that edge,
//    discards buffered points, count=0.
//  - o_SIU_ready = i_cfg_enable & !fifo_full (full evaluated before same-cycle pop; no bypass).
//  - Payload: [15:0]distR0 [23:16]reflR0 [39:24]distR1 [47:40]reflR1 [55:48]correction [63:56]label.
//  - Address = i_cfg_base_addr + ({zero-ext index} << 3), mod 2^ADDR_W (wraps, no flag).
//    Address computed and stored at accept time; base change affects only later points.
//  - FSM IDLE: if FIFO non-empty, load head into addr/data regs, req=1 next edge -> REQ.
//    Latency: point accepted at edge N -> req=1 after edge N+1.
//  - FSM REQ: req/addr/data held stable until ack. On ack: pop head, count+1; if another entry
//    remains, load it and keep req=1 (back-to-back, 1 write/cycle max); else req=0 -> IDLE.
//  - Ack while req=0 ignored. Push and pop same cycle allowed; occupancy unchanged.
//  - Count saturates at all-ones. clear & ack same cycle -> count=0 (clear wins).
//  - i_cfg_enable=0 blocks intake only; buffered points still drain.
//  - busy = !fifo_empty | o_MEM_wr_req.
// STRUCTURE
//  - Package memmu_sr_pkg: SR_PAYLOAD_W=64, payload field offsets/widths, SR_CELL_BYTES_LOG2=3,
//    FSM state typedef {IDLE, REQ}.
//  - Sub-module memmu_sr_wfifo: sync FIFO, width ADDR_W+64, depth FIFO_DEPTH, full/empty flags.
//  - Payload packing via existing MemMU_sphericalRepresentationPayload instance.
// TESTING
//  1 Single point: base=0x1000, idx=5, distR0=0x1234, reflR0=0xAA, distR1=0x5678, reflR1=0xBB,
//    corr=0x0C, label=0x03 -> req after 1 cycle, addr=0x1028, data=0x030CBB5678AA1234; ack -> count=1.
//  2 Backpressure: ack held 0, push 5 points -> ready low after 4th; req/addr/data stable;
//    ack every cycle -> 4 writes back-to-back, then 5th, count=5, busy falls.
//  3 Wrap: ADDR_W=32, base=0xFFFFFFF8, idx=2 -> addr=0x00000008.
//  4 Reset mid-REQ with 3 buffered -> req=0, busy=0, count=0 next cycle; no further writes.
//  5 clear and ack same cycle at count=7 -> count=0; enable=0 with 2 buffered -> both drain, ready=0.
//  6 Spurious ack with req=0 -> count unchanged; saturation: IDX_W=2 force 8 writes -> count=7.

Source files
------------

// File: rtl/memmu_sr_pkg.sv
// Shared constants for the MemMU spherical-representation write path.
// Holds the payload field layout, the cell size and the writer FSM state type.
package memmu_sr_pkg;

   localparam int SR_PAYLOAD_W       = 64;
   localparam int SR_DIST_W          = 16;
   localparam int SR_BYTE_W          = 8;
   localparam int SR_DIST_R0_LSB     = 0;
   localparam int SR_REFL_R0_LSB     = 16;
   localparam int SR_DIST_R1_LSB     = 24;
   localparam int SR_REFL_R1_LSB     = 40;
   localparam int SR_CORR_LSB        = 48;
   localparam int SR_LABEL_LSB       = 56;
   localparam int SR_CELL_BYTES_LOG2 = 3;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } srWrState_t;

endpackage

// File: rtl/MemMU_sphericalRepresentationPayload.sv
// Packs one SIU point into the 64-bit SR payload word.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module MemMU_sphericalRepresentationPayload
   import memmu_sr_pkg::*;
(
   input  logic [15:0]             distR0,
   input  logic [15:0]             distR1,
   input  logic [7:0]              reflR0,
   input  logic [7:0]              reflR1,
   input  logic [7:0]              correction,
   input  logic [7:0]              label,
   output logic [SR_PAYLOAD_W-1:0] payload
);

   always_comb begin
      payload = '0;
      payload[SR_DIST_R0_LSB +: SR_DIST_W] = distR0;
      payload[SR_REFL_R0_LSB +: SR_BYTE_W] = reflR0;
      payload[SR_DIST_R1_LSB +: SR_DIST_W] = distR1;
      payload[SR_REFL_R1_LSB +: SR_BYTE_W] = reflR1;
      payload[SR_CORR_LSB    +: SR_BYTE_W] = correction;
      payload[SR_LABEL_LSB   +: SR_BYTE_W] = label;
   end

endmodule

// File: rtl/memmu_sr_wfifo.sv
// Synchronous FIFO exposing the head and the entry behind it for back-to-back issue.
// Latency: a push is visible at the head one cycle later; no bypass.
// Backpressure: caller must not push while full nor pop while empty.
module memmu_sr_wfifo #(
   parameter int W     = 96,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] pushData,
   input  logic         pop,
   output logic [W-1:0] headData,
   output logic [W-1:0] nextData,
   output logic         full,
   output logic         empty,
   output logic         twoPlus
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW:0]   wrPtr;
   logic [AW:0]   rdPtr;
   logic [AW:0]   occupancy;
   logic [AW-1:0] nextIdx;

   assign occupancy = wrPtr - rdPtr;
   assign full      = (occupancy == (AW+1)'(DEPTH));
   assign empty     = (occupancy == '0);
   assign twoPlus   = (occupancy >= (AW+1)'(2));
   assign nextIdx   = rdPtr[AW-1:0] + AW'(1);
   assign headData  = mem[rdPtr[AW-1:0]];
   assign nextData  = mem[nextIdx];

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + (AW+1)'(1);
         if (pop)  rdPtr <= rdPtr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wrPtr[AW-1:0]] <= pushData;
   end

endmodule

// File: rtl/memmu_sr_payload_writer.sv
// Buffers SIU points as {address, payload} and issues one req/ack memory write per point.
// Latency: point accepted at edge N raises req after edge N+1; up to one write per cycle.
// Backpressure: ready drops while the buffer is full; the head stays buffered until acked.
module memmu_sr_payload_writer
   import memmu_sr_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int IDX_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    i_SYSTEM_clk,
   input  logic                    i_SYSTEM_rst,
   input  logic                    i_cfg_enable,
   input  logic                    i_cfg_clear,
   input  logic [ADDR_W-1:0]       i_cfg_base_addr,
   input  logic                    i_SIU_valid,
   output logic                    o_SIU_ready,
   input  logic [15:0]             i_SIU_distR0,
   input  logic [15:0]             i_SIU_distR1,
   input  logic [7:0]              i_SIU_reflR0,
   input  logic [7:0]              i_SIU_reflR1,
   input  logic [7:0]              i_SIU_label,
   input  logic [7:0]              i_MemMU_SR_A_correction,
   input  logic [IDX_W-1:0]        i_MemMU_SR_A_index,
   output logic                    o_MEM_wr_req,
   output logic [ADDR_W-1:0]       o_MEM_wr_addr,
   output logic [SR_PAYLOAD_W-1:0] o_MEM_wr_data,
   input  logic                    i_MEM_wr_ack,
   output logic [IDX_W:0]          o_MemMU_SR_W_count,
   output logic                    o_MemMU_SR_W_busy
);

   typedef struct packed {
      logic [ADDR_W-1:0]       addr;
      logic [SR_PAYLOAD_W-1:0] data;
   } wrEntry_t;

   wrEntry_t                pushEnt;
   wrEntry_t                headEnt;
   wrEntry_t                nextEnt;
   logic [SR_PAYLOAD_W-1:0] payload;
   logic                    fifoFull;
   logic                    fifoEmpty;
   logic                    fifoTwoPlus;
   logic                    push;
   logic                    pop;
   srWrState_t              state;

   MemMU_sphericalRepresentationPayload uPayload (
      .distR0     (i_SIU_distR0),
      .distR1     (i_SIU_distR1),
      .reflR0     (i_SIU_reflR0),
      .reflR1     (i_SIU_reflR1),
      .correction (i_MemMU_SR_A_correction),
      .label      (i_SIU_label),
      .payload    (payload)
   );

   // Address is frozen at accept time so later base changes only affect later points.
   assign pushEnt.addr = i_cfg_base_addr + (ADDR_W'(i_MemMU_SR_A_index) << SR_CELL_BYTES_LOG2);
   assign pushEnt.data = payload;

   assign o_SIU_ready       = i_cfg_enable & ~fifoFull & ~i_SYSTEM_rst;
   assign push              = i_SIU_valid & o_SIU_ready;
   assign pop               = i_MEM_wr_ack & o_MEM_wr_req;
   assign o_MemMU_SR_W_busy = ~fifoEmpty | o_MEM_wr_req;

   memmu_sr_wfifo #(
      .W     ($bits(wrEntry_t)),
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clk      (i_SYSTEM_clk),
      .rst      (i_SYSTEM_rst),
      .push     (push),
      .pushData (pushEnt),
      .pop      (pop),
      .headData (headEnt),
      .nextData (nextEnt),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .twoPlus  (fifoTwoPlus)
   );

   always_ff @(posedge i_SYSTEM_clk) begin
      if (i_SYSTEM_rst) begin
         state         <= IDLE;
         o_MEM_wr_req  <= 1'b0;
         o_MEM_wr_addr <= '0;
         o_MEM_wr_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifoEmpty) begin
                  o_MEM_wr_req  <= 1'b1;
                  o_MEM_wr_addr <= headEnt.addr;
                  o_MEM_wr_data <= headEnt.data;
                  state         <= REQ;
               end
            end
            REQ: begin
               // The entry behind the head becomes the new head once this ack pops it.
               if (i_MEM_wr_ack) begin
                  if (fifoTwoPlus) begin
                     o_MEM_wr_addr <= nextEnt.addr;
                     o_MEM_wr_data <= nextEnt.data;
                  end else begin
                     o_MEM_wr_req <= 1'b0;
                     state        <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_SYSTEM_clk) begin
      if (i_SYSTEM_rst || i_cfg_clear) begin
         o_MemMU_SR_W_count <= '0;
      end else if (pop && (o_MemMU_SR_W_count != '1)) begin
         o_MemMU_SR_W_count <= o_MemMU_SR_W_count + (IDX_W+1)'(1);
      end
   end

endmodule

// File: tb/tb_memmu_sr_payload_writer.sv
// Scenario bench for memmu_sr_payload_writer against a queue-based model of expected writes.
// A second instance with a 2-bit index exercises counter saturation.
module tb_memmu_sr_payload_writer;

   typedef struct packed {
      logic [31:0] addr;
      logic [63:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst, enable, clear, valid, ack;
   logic [31:0] base;
   logic [15:0] idxIn, d0, d1;
   logic [7:0]  r0, r1, corr, lab;
   logic        ready, req, busy;
   logic [31:0] addr;
   logic [63:0] data;
   logic [16:0] count;

   logic        sValid, sAck, sReady, sReq, sBusy;
   logic [31:0] sAddr;
   logic [63:0] sData;
   logic [2:0]  sCount;

   int  checks = 0;
   int  errors = 0;
   int  cyc    = 0;
   wr_t expQ[$];
   wr_t obsQ[$];
   int  obsCyc[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   memmu_sr_payload_writer dut (
      .i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst), .i_cfg_enable(enable), .i_cfg_clear(clear),
      .i_cfg_base_addr(base), .i_SIU_valid(valid), .o_SIU_ready(ready),
      .i_SIU_distR0(d0), .i_SIU_distR1(d1), .i_SIU_reflR0(r0), .i_SIU_reflR1(r1),
      .i_SIU_label(lab), .i_MemMU_SR_A_correction(corr), .i_MemMU_SR_A_index(idxIn),
      .o_MEM_wr_req(req), .o_MEM_wr_addr(addr), .o_MEM_wr_data(data), .i_MEM_wr_ack(ack),
      .o_MemMU_SR_W_count(count), .o_MemMU_SR_W_busy(busy));

   memmu_sr_payload_writer #(.ADDR_W(32), .IDX_W(2), .FIFO_DEPTH(4)) dutSat (
      .i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst), .i_cfg_enable(enable), .i_cfg_clear(clear),
      .i_cfg_base_addr(base), .i_SIU_valid(sValid), .o_SIU_ready(sReady),
      .i_SIU_distR0(d0), .i_SIU_distR1(d1), .i_SIU_reflR0(r0), .i_SIU_reflR1(r1),
      .i_SIU_label(lab), .i_MemMU_SR_A_correction(corr), .i_MemMU_SR_A_index(idxIn[1:0]),
      .o_MEM_wr_req(sReq), .o_MEM_wr_addr(sAddr), .o_MEM_wr_data(sData), .i_MEM_wr_ack(sAck),
      .o_MemMU_SR_W_count(sCount), .o_MemMU_SR_W_busy(sBusy));

   // A handshake seen at the falling edge completes at the following rising edge.
   always @(negedge clk) begin
      if (!rst && req && ack) begin
         obsQ.push_back('{addr: addr, data: data});
         obsCyc.push_back(cyc);
      end
   end

   function automatic wr_t model(input logic [31:0] b, input logic [15:0] idx,
                                 input logic [15:0] dist0, dist1,
                                 input logic [7:0] refl0, refl1, cr, lb);
      wr_t       m;
      longint    a;
      a = longint'(b) + longint'(idx) * 8;
      m.addr = a[31:0];
      m.data = 64'(dist0) + 64'(refl0) * 64'h1_0000 + 64'(dist1) * 64'h100_0000
             + 64'(refl1) * 64'h100_0000_0000 + 64'(cr) * 64'h1_0000_0000_0000
             + 64'(lb) * 64'h100_0000_0000_0000;
      return m;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1; valid = 1'b0; ack = 1'b0; clear = 1'b0; sValid = 1'b0; sAck = 1'b0;
      step();
      step();
      rst = 1'b0;
      expQ.delete();
      obsQ.delete();
      obsCyc.delete();
   endtask

   task automatic setFields(input logic [15:0] idx, dist0, dist1, input logic [7:0] refl0, refl1, cr, lb);
      idxIn = idx; d0 = dist0; d1 = dist1; r0 = refl0; r1 = refl1; corr = cr; lab = lb;
   endtask

   task automatic setRandomFields();
      setFields(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom), 8'($urandom));
   endtask

   task automatic pushRandom();
      bit done;
      done = 1'b0;
      setRandomFields();
      valid = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         #1;
         if (ready) begin
            expQ.push_back(model(base, idxIn, d0, d1, r0, r1, corr, lab));
            done = 1'b1;
         end
         step();
      end
      valid = 1'b0;
      checks++;
      if (!done) begin errors++; $display("FAIL push_timeout: accepted=%0d required=1", done); end
   endtask

   task automatic waitReq();
      int n;
      n = 0;
      while (!req && n < 40) begin step(); n++; end
      checks++;
      if (!req) begin errors++; $display("FAIL wait_req: req=%0b required=1", req); end
   endtask

   task automatic drainAll();
      int n;
      n = 0;
      ack = 1'b1;
      while (busy && n < 60) begin step(); n++; end
      ack = 1'b0;
      checks++;
      if (busy) begin errors++; $display("FAIL drain: busy=%0b required=0", busy); end
   endtask

   task automatic compareWrites(input string tag);
      checks++;
      if (obsQ.size() !== expQ.size()) begin
         errors++;
         $display("FAIL %s_nwrites: got %0d expected %0d", tag, obsQ.size(), expQ.size());
      end
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
         checks++;
         if (obsQ[i] !== expQ[i]) begin
            errors++;
            $display("FAIL %s_write%0d: got %h/%h expected %h/%h", tag, i,
                     obsQ[i].addr, obsQ[i].data, expQ[i].addr, expQ[i].data);
         end
      end
   endtask

   task automatic test_reset();
      enable = 1'b1; base = 32'h0;
      rst = 1'b1; valid = 1'b1; ack = 1'b0; clear = 1'b0; sValid = 1'b0; sAck = 1'b0;
      setRandomFields();
      step();
      step();
      checks++; if (req !== 1'b0)  begin errors++; $display("FAIL rst_req: got %b expected 0", req); end
      checks++; if (addr !== '0)   begin errors++; $display("FAIL rst_addr: got %h expected 0", addr); end
      checks++; if (data !== '0)   begin errors++; $display("FAIL rst_data: got %h expected 0", data); end
      checks++; if (count !== '0)  begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", ready); end
      valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_single();
      wr_t m;
      doReset();
      enable = 1'b1; base = 32'h1000;
      setFields(16'd5, 16'h1234, 16'h5678, 8'hAA, 8'hBB, 8'h0C, 8'h03);
      m = model(base, idxIn, d0, d1, r0, r1, corr, lab);
      valid = 1'b1;
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", ready); end
      step();
      valid = 1'b0;
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL single_req_early: got %b expected 0", req); end
      step();
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL single_req: got %b expected 1", req); end
      checks++; if (addr !== 32'h1028) begin errors++; $display("FAIL single_addr: got %h expected 00001028", addr); end
      checks++; if (data !== 64'h030CBB5678AA1234) begin errors++; $display("FAIL single_data: got %h expected 030cbb5678aa1234", data); end
      checks++; if ({addr, data} !== {m.addr, m.data}) begin errors++; $display("FAIL single_model: got %h/%h expected %h/%h", addr, data, m.addr, m.data); end
      ack = 1'b1;
      step();
      ack = 1'b0;
      checks++; if (count !== 17'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
      checks++; if (req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: req=%b busy=%b expected 0/0", req, busy); end
   endtask

   task automatic test_back_to_back();
      bit acc;
      int n;
      doReset();
      enable = 1'b1; base = $urandom;
      for (int i = 0; i < 4; i++) pushRandom();
      setRandomFields();
      valid = 1'b1;
      #1;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", ready); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (req !== 1'b1 || addr !== expQ[0].addr || data !== expQ[0].data) begin
            errors++;
            $display("FAIL bp_hold%0d: req=%b %h/%h expected 1 %h/%h", i, req, addr, data, expQ[0].addr, expQ[0].data);
         end
      end
      ack = 1'b1;
      n = 0;
      while ((obsQ.size() < 5 || busy) && n < 40) begin
         acc = 1'b0;
         #1;
         if (valid && ready) begin
            expQ.push_back(model(base, idxIn, d0, d1, r0, r1, corr, lab));
            acc = 1'b1;
         end
         step();
         if (acc) valid = 1'b0;
         n++;
      end
      ack = 1'b0;
      valid = 1'b0;
      compareWrites("bp");
      for (int i = 0; i < 3 && i + 1 < obsCyc.size(); i++) begin
         checks++;
         if (obsCyc[i+1] !== obsCyc[i] + 1) begin errors++; $display("FAIL bp_b2b%0d: gap %0d expected 1", i, obsCyc[i+1] - obsCyc[i]); end
      end
      checks++; if (count !== 17'd5) begin errors++; $display("FAIL bp_count: got %0d expected 5", count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy: got %b expected 0", busy); end
   endtask

   task automatic test_wrap();
      doReset();
      enable = 1'b1; base = 32'hFFFF_FFF8;
      setFields(16'd2, 16'h1, 16'h2, 8'h3, 8'h4, 8'h5, 8'h6);
      valid = 1'b1;
      step();
      valid = 1'b0;
      waitReq();
      checks++; if (addr !== 32'h0000_0008) begin errors++; $display("FAIL wrap_addr: got %h expected 00000008", addr); end
      drainAll();
   endtask

   task automatic test_reset_mid();
      int n;
      doReset();
      enable = 1'b1; base = $urandom;
      for (int i = 0; i < 4; i++) pushRandom();
      waitReq();
      ack = 1'b1;
      step();
      ack = 1'b0;
      checks++; if (count !== 17'd1 || req !== 1'b1) begin errors++; $display("FAIL mid_pre: count=%0d req=%b expected 1/1", count, req); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (req !== 1'b0)  begin errors++; $display("FAIL mid_req: got %b expected 0", req); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
      checks++; if (count !== '0)  begin errors++; $display("FAIL mid_count: got %0d expected 0", count); end
      n = obsQ.size();
      ack = 1'b1;
      for (int i = 0; i < 10; i++) step();
      ack = 1'b0;
      checks++; if (obsQ.size() !== n || req !== 1'b0) begin errors++; $display("FAIL mid_nowrite: writes=%0d req=%b expected %0d/0", obsQ.size(), req, n); end
   endtask

   task automatic test_clear_enable();
      bit rdyBad;
      int n;
      doReset();
      enable = 1'b1; base = $urandom;
      ack = 1'b1;
      for (int i = 0; i < 6; i++) pushRandom();
      drainAll();
      checks++; if (count !== 17'd6) begin errors++; $display("FAIL ce_count6: got %0d expected 6", count); end
      for (int i = 0; i < 4; i++) pushRandom();
      waitReq();
      ack = 1'b1;
      step();
      ack = 1'b0;
      checks++; if (count !== 17'd7) begin errors++; $display("FAIL ce_count7: got %0d expected 7", count); end
      clear = 1'b1; ack = 1'b1;
      step();
      clear = 1'b0; ack = 1'b0;
      checks++; if (count !== '0) begin errors++; $display("FAIL ce_clear_wins: got %0d expected 0", count); end
      enable = 1'b0;
      setRandomFields();
      valid = 1'b1;
      rdyBad = 1'b0;
      ack = 1'b1;
      n = 0;
      while (busy && n < 40) begin
         #1;
         if (ready) rdyBad = 1'b1;
         step();
         n++;
      end
      ack = 1'b0; valid = 1'b0; enable = 1'b1;
      checks++; if (rdyBad) begin errors++; $display("FAIL ce_ready_disabled: got 1 expected 0"); end
      checks++; if (count !== 17'd2 || busy !== 1'b0) begin errors++; $display("FAIL ce_drain: count=%0d busy=%b expected 2/0", count, busy); end
      compareWrites("ce");
   endtask

   task automatic test_spurious();
      doReset();
      enable = 1'b1; base = $urandom;
      pushRandom();
      pushRandom();
      drainAll();
      ack = 1'b1;
      for (int i = 0; i < 4; i++) step();
      ack = 1'b0;
      checks++; if (count !== 17'd2 || req !== 1'b0) begin errors++; $display("FAIL spurious: count=%0d req=%b expected 2/0", count, req); end
   endtask

   task automatic test_random();
      bit acc;
      int n;
      doReset();
      enable = 1'b1; base = $urandom;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(7) == 0) base = $urandom;
         enable = ($urandom_range(9) != 0);
         ack = ($urandom_range(9) < 6);
         if (!valid && $urandom_range(2) != 0) begin setRandomFields(); valid = 1'b1; end
         acc = 1'b0;
         #1;
         if (!enable) begin
            checks++;
            if (ready !== 1'b0) begin errors++; $display("FAIL rnd_ready_dis: got %b expected 0", ready); end
         end
         if (valid && ready) begin
            expQ.push_back(model(base, idxIn, d0, d1, r0, r1, corr, lab));
            acc = 1'b1;
         end
         step();
         if (acc) valid = 1'b0;
      end
      valid = 1'b0; enable = 1'b1;
      drainAll();
      compareWrites("rnd");
      n = (expQ.size() > 131071) ? 131071 : expQ.size();
      checks++; if (count !== 17'(n)) begin errors++; $display("FAIL rnd_count: got %0d expected %0d", count, n); end
   endtask

   task automatic test_saturation();
      int n;
      doReset();
      enable = 1'b1; base = $urandom;
      sAck = 1'b1;
      for (int p = 0; p < 8; p++) begin
         setRandomFields();
         sValid = 1'b1;
         n = 0;
         #1;
         while (!sReady && n < 40) begin step(); n++; end
         step();
         sValid = 1'b0;
         n = 0;
         while (sBusy && n < 40) begin step(); n++; end
         if (p == 6) begin
            checks++; if (sCount !== 3'd7) begin errors++; $display("FAIL sat_count7: got %0d expected 7", sCount); end
         end
      end
      sAck = 1'b0;
      checks++; if (sCount !== 3'd7) begin errors++; $display("FAIL sat_count8: got %0d expected 7", sCount); end
      checks++; if (sBusy !== 1'b0) begin errors++; $display("FAIL sat_busy: got %b expected 0", sBusy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      test_clear_enable();
      test_spurious();
      test_random();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
